branch_resolve_queue: RTL and testbench

In-order tracker of in-flight branch predictions, sitting between fetch (which consults the branch history table) and execute (which resolves branches). It records each prediction at fetch, compares it with the execute-stage outcome, and emits the branch history table update stream (write index plus taken flag). On a mispredict it emits a flush/redirect and discards all younger in-flight predictions.

---
 rtl/bp_pkg.sv | 11 +
 rtl/bp_entry_fifo.sv | 39 +++
 rtl/branch_resolve_queue.sv | 78 +++++++
 tb/tb_branch_resolve_queue.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared types and constants for the branch resolve queue
package bp_pkg;
  localparam int INSTR_BYTES = 4;
  localparam int ENTRY_PC_W = 32;
  typedef enum logic {RUN, RECOVER} state_t;
  typedef struct packed {
    logic [ENTRY_PC_W-1:0] pc;
    logic                  taken;
    logic [ENTRY_PC_W-1:0] target;
  } entry_t;
endpackage

// File: rtl/bp_entry_fifo.sv
// bp_entry_fifo: circular buffer of in-flight predictions with push/pop/clear
module bp_entry_fifo
  import bp_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  entry_t                 din,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  entry_t mem [DEPTH];
  logic [AW-1:0] hd, tl;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      hd    <= '0;
      tl    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      hd    <= '0;
      tl    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tl] <= din;
        tl      <= tl + AW'(1);
      end
      if (pop) hd <= hd + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  assign head = mem[hd];
endmodule

// File: rtl/branch_resolve_queue.sv
// branch_resolve_queue: tracks in-flight branch predictions, resolves them in order and emits BHT updates and flushes
module branch_resolve_queue
  import bp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int IDX_W = 5,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   arst_n,
  input  logic                   pred_valid,
  input  logic [PC_W-1:0]        pred_pc,
  input  logic                   pred_taken,
  input  logic [PC_W-1:0]        pred_target,
  output logic                   pred_ready,
  input  logic                   res_valid,
  input  logic                   res_taken,
  input  logic [PC_W-1:0]        res_target,
  output logic                   upd_valid,
  output logic [IDX_W-1:0]       upd_addr,
  output logic                   upd_taken,
  output logic                   flush,
  output logic [PC_W-1:0]        redirect_pc,
  output logic [$clog2(DEPTH):0] count,
  output logic [CNT_W-1:0]       mispredicts,
  output logic                   err_underflow
);
  localparam int CW = $clog2(DEPTH) + 1;
  state_t state, state_nx;
  entry_t head, din;
  logic [PC_W-1:0] head_pc, head_tg;
  logic resolve, mis, push;
  assign head_pc = PC_W'(head.pc);
  assign head_tg = PC_W'(head.target);
  assign din     = '{pc: ENTRY_PC_W'(pred_pc), taken: pred_taken, target: ENTRY_PC_W'(pred_target)};
  assign resolve = res_valid && count != '0 && state == RUN;
  assign mis     = resolve && (res_taken != head.taken || (res_taken && res_target != head_tg));
  // a push racing a mispredict is on the wrong path and is dropped
  assign push    = pred_valid && pred_ready && !mis;
  bp_entry_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .arst_n(arst_n),
    .push  (push),
    .pop   (resolve && !mis),
    .clear (mis),
    .din   (din),
    .head  (head),
    .count (count)
  );
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= RUN;
    else state <= state_nx;
  end
  always_comb state_nx = mis ? RECOVER : RUN;
  always_comb pred_ready = count < CW'(DEPTH) && state == RUN;
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      upd_valid     <= 1'b0;
      upd_addr      <= '0;
      upd_taken     <= 1'b0;
      flush         <= 1'b0;
      redirect_pc   <= '0;
      mispredicts   <= '0;
      err_underflow <= 1'b0;
    end else begin
      upd_valid <= resolve;
      flush     <= mis;
      if (resolve) begin
        upd_addr  <= head_pc[IDX_W+1:2];
        upd_taken <= res_taken;
      end
      if (mis) redirect_pc <= res_taken ? res_target : head_pc + PC_W'(INSTR_BYTES);
      if (mis && !(&mispredicts)) mispredicts <= mispredicts + CNT_W'(1);
      if (res_valid && count == '0 && state == RUN) err_underflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_resolve_queue.sv
// tb_branch_resolve_queue: directed and random checks against a queue-based reference model
module tb_branch_resolve_queue;
  logic clk = 1'b0, arst_n = 1'b0;
  logic pred_valid = 0, pred_taken = 0, res_valid = 0, res_taken = 0;
  logic [31:0] pred_pc = 0, pred_target = 0, res_target = 0;
  logic pred_ready, upd_valid, upd_taken, flush, err_underflow;
  logic [4:0] upd_addr;
  logic [31:0] redirect_pc;
  logic [2:0] count;
  logic [15:0] mispredicts;
  int checks = 0, errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic        t;
    logic [31:0] tg;
  } ment_t;
  ment_t q[$];
  logic rec = 0, e_uv = 0, e_ut = 0, e_fl = 0, e_err = 0;
  logic [4:0] e_ua = 0;
  logic [31:0] e_rp = 0;
  logic [15:0] e_mc = 0;

  always #5 clk = ~clk;

  branch_resolve_queue dut (
    .clk(clk), .arst_n(arst_n),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_ready(pred_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_taken(upd_taken),
    .flush(flush), .redirect_pc(redirect_pc), .count(count),
    .mispredicts(mispredicts), .err_underflow(err_underflow)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, "_count"}, 64'(count), 64'(q.size()));
    chk({tag, "_ready"}, 64'(pred_ready), 64'(q.size() < 4 && !rec));
    chk({tag, "_uv"}, 64'(upd_valid), 64'(e_uv));
    chk({tag, "_flush"}, 64'(flush), 64'(e_fl));
    chk({tag, "_misc"}, 64'(mispredicts), 64'(e_mc));
    chk({tag, "_err"}, 64'(err_underflow), 64'(e_err));
    if (e_uv) begin
      chk({tag, "_ua"}, 64'(upd_addr), 64'(e_ua));
      chk({tag, "_ut"}, 64'(upd_taken), 64'(e_ut));
    end
    if (e_fl) chk({tag, "_rpc"}, 64'(redirect_pc), 64'(e_rp));
  endtask

  task automatic step(input string tag, input logic pv, input logic [31:0] pc, input logic pt,
                      input logic [31:0] ptg, input logic rv, input logic rt, input logic [31:0] rtg);
    logic ready, res, mis;
    @(negedge clk);
    pred_valid = pv; pred_pc = pc; pred_taken = pt; pred_target = ptg;
    res_valid = rv; res_taken = rt; res_target = rtg;
    ready = q.size() < 4 && !rec;
    res = rv && q.size() > 0 && !rec;
    if (rv && q.size() == 0 && !rec) e_err = 1;
    mis = res && (rt != q[0].t || (rt && rtg != q[0].tg));
    e_uv = res;
    e_fl = mis;
    if (res) begin
      e_ua = q[0].pc[6:2];
      e_ut = rt;
    end
    if (mis) begin
      e_rp = rt ? rtg : q[0].pc + 32'd4;
      if (e_mc != 16'hFFFF) e_mc++;
      q.delete();
    end else begin
      if (res) void'(q.pop_front());
      if (pv && ready) q.push_back('{pc, pt, ptg});
    end
    rec = mis;
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic resolve_ok(input string tag);
    step(tag, 0, 0, 0, 0, 1, q[0].t, q[0].tg);
  endtask

  task automatic model_reset();
    q.delete();
    rec = 0; e_uv = 0; e_ut = 0; e_fl = 0; e_err = 0; e_ua = 0; e_rp = 0; e_mc = 0;
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst_ready", 64'(pred_ready), 64'd1);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_uv", 64'(upd_valid), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_rpc", 64'(redirect_pc), 64'd0);
    @(negedge clk);
    arst_n = 1;

    step("tp1_push", 1, 32'h40, 1, 32'h80, 0, 0, 0);
    step("tp1_res", 0, 0, 0, 0, 1, 1, 32'h80);
    chk("tp1_addr", 64'(upd_addr), 64'h10);

    step("tp2_push", 1, 32'h44, 0, 32'h0, 0, 0, 0);
    step("tp2_res", 0, 0, 0, 0, 1, 1, 32'h100);
    chk("tp2_rpc", 64'(redirect_pc), 64'h100);
    chk("tp2_ready", 64'(pred_ready), 64'd0);
    idle("tp2_after");

    step("tp3_p0", 1, 32'h48, 1, 32'h90, 0, 0, 0);
    step("tp3_p1", 1, 32'h4C, 0, 32'h0, 0, 0, 0);
    step("tp3_p2", 1, 32'h50, 1, 32'hA0, 0, 0, 0);
    step("tp3_p3", 1, 32'h54, 0, 32'h0, 0, 0, 0);
    step("tp3_res", 1, 32'h58, 0, 32'h0, 1, 0, 32'h0);
    chk("tp3_rpc", 64'(redirect_pc), 64'h4C);
    step("tp3_rec", 1, 32'h5C, 0, 32'h0, 1, 0, 32'h0);
    idle("tp3_after");

    for (int i = 0; i < 4; i++) step("fill", 1, 32'h100 + 32'(i * 4), i[0], 32'h200 + 32'(i * 8), 0, 0, 0);
    step("full_pp", 1, 32'h180, 0, 0, 1, q[0].t, q[0].tg);
    for (int i = 0; i < 10; i++) step("wrap", 1, 32'h300 + 32'(i * 4), i[1], 32'h400 + 32'(i * 4), 1, q[0].t, q[0].tg);
    while (q.size() > 0) resolve_ok("drain");

    step("under", 0, 0, 0, 0, 1, 1, 32'h0);
    idle("under_sticky");
    chk("under_flag", 64'(err_underflow), 64'd1);

    step("pre_rst0", 1, 32'h20, 1, 32'h30, 0, 0, 0);
    step("pre_rst1", 1, 32'h24, 0, 32'h0, 1, 0, 32'h0);
    @(negedge clk);
    pred_valid = 0; res_valid = 0;
    arst_n = 0;
    #1;
    model_reset();
    chk_all("arst");
    chk("arst_ua", 64'(upd_addr), 64'd0);
    chk("arst_ut", 64'(upd_taken), 64'd0);
    chk("arst_rpc", 64'(redirect_pc), 64'd0);
    #2 arst_n = 1;

    for (int i = 0; i < 600; i++) begin
      logic pv, pt, rv, rt;
      logic [31:0] pc, ptg, rtg;
      pv = $urandom_range(0, 99) < 60;
      pc = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      pt = 1'($urandom_range(0, 1));
      ptg = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      rv = $urandom_range(0, 99) < 45;
      if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
        rt = q[0].t;
        rtg = q[0].tg;
      end else begin
        rt = 1'($urandom_range(0, 1));
        rtg = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      end
      step("rand", pv, pc, pt, ptg, rv, rt, rtg);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
